// File: rtl/wb_arbiter_pkg.sv
// Shared widths, constants and arbitration source encoding for the register-file
// writeback arbiter.
package wb_arbiter_pkg;

    localparam int unsigned WB_ADDR_W   = 5;
    localparam int unsigned WB_DATA_W   = 32;
    localparam int unsigned WB_REG_ZERO = 0;

    typedef enum logic [1:0] {
        SrcNone = 2'd0,
        SrcPipe = 2'd1,
        SrcFifo = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO buffering long-unit results until they win the RF write port.
// Caller guarantees no push when full and no pop when empty.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = WB_ADDR_W + WB_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage needs no reset: occupancy is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: merges pipeline writebacks with queued long-unit
// results, tracks outstanding long-unit destinations and forces a stall on starvation.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned ADDR_W     = WB_ADDR_W,
    parameter int unsigned DATA_W     = WB_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_wr,
    input  logic [ADDR_W-1:0]    pipe_rd,
    input  logic [DATA_W-1:0]    pipe_data,
    input  logic                 lu_valid,
    output logic                 lu_ready,
    input  logic [ADDR_W-1:0]    lu_rd,
    input  logic [DATA_W-1:0]    lu_data,
    input  logic                 issue_vld,
    input  logic [ADDR_W-1:0]    issue_rd,
    output logic                 RFWr,
    output logic [ADDR_W-1:0]    WrDtAdr,
    output logic [DATA_W-1:0]    WrDt,
    output logic [2**ADDR_W-1:0] busy,
    output logic                 wb_stall
);
    localparam int unsigned NREG     = 2 ** ADDR_W;
    localparam int unsigned ENT_W    = ADDR_W + DATA_W;
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1) < 1 ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0]   RegZero   = ADDR_W'(WB_REG_ZERO);
    localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_MAX);

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [ENT_W-1:0]    w_head;
    logic [ADDR_W-1:0]   w_head_rd;
    logic [DATA_W-1:0]   w_head_data;
    logic                w_push;
    logic                w_pop;
    logic                w_pipe_req;
    wb_src_e             w_src;
    logic [STARVE_W-1:0] w_starve_d;
    logic                w_stall_d;
    logic [NREG-1:0]     w_busy_d;

    logic [STARVE_W-1:0] r_starve;
    logic                r_stall;
    logic                r_rf_wr;
    logic [ADDR_W-1:0]   r_wr_adr;
    logic [DATA_W-1:0]   r_wr_dat;
    logic [NREG-1:0]     r_busy;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({lu_rd, lu_data}),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign {w_head_rd, w_head_data} = w_head;

    // Ready comes from registered occupancy only, so a full FIFO stays closed while popping.
    assign lu_ready   = !w_fifo_full;
    assign w_push     = lu_valid && !w_fifo_full && (lu_rd != RegZero);
    assign w_pipe_req = pipe_wr && (pipe_rd != RegZero);

    always_comb begin
        w_src = SrcNone;
        if (r_stall) begin
            w_src = w_fifo_empty ? SrcNone : SrcFifo;
        end else if (w_pipe_req) begin
            w_src = SrcPipe;
        end else if (!w_fifo_empty) begin
            w_src = SrcFifo;
        end
    end

    assign w_pop = (w_src == SrcFifo);

    // Counter saturates at the threshold; the one-cycle stall pop then clears it.
    always_comb begin
        w_starve_d = r_starve;
        if (w_fifo_empty || w_pop) begin
            w_starve_d = '0;
        end else if ((w_src == SrcPipe) && (r_starve != StarveMax)) begin
            w_starve_d = r_starve + STARVE_W'(1);
        end
    end

    assign w_stall_d = (r_starve == StarveMax) && !r_stall;

    always_comb begin
        w_busy_d = r_busy;
        if (w_pop) begin
            w_busy_d[w_head_rd] = 1'b0;
        end
        if (issue_vld && (issue_rd != RegZero)) begin
            w_busy_d[issue_rd] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
            r_rf_wr  <= 1'b0;
            r_wr_adr <= '0;
            r_wr_dat <= '0;
            r_busy   <= '0;
        end else begin
            r_starve <= w_starve_d;
            r_stall  <= w_stall_d;
            r_busy   <= w_busy_d;
            r_rf_wr  <= (w_src != SrcNone);
            case (w_src)
                SrcPipe: begin
                    r_wr_adr <= pipe_rd;
                    r_wr_dat <= pipe_data;
                end
                SrcFifo: begin
                    r_wr_adr <= w_head_rd;
                    r_wr_dat <= w_head_data;
                end
                default: ;
            endcase
        end
    end

    assign RFWr     = r_rf_wr;
    assign WrDtAdr  = r_wr_adr;
    assign WrDt     = r_wr_dat;
    assign busy     = r_busy;
    assign wb_stall = r_stall;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, starvation and reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wr;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        issue_vld;
    logic [4:0]  issue_rd;
    logic        RFWr;
    logic [4:0]  WrDtAdr;
    logic [31:0] WrDt;
    logic [31:0] busy;
    logic        wb_stall;

    wb_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX),
        .ADDR_W     (5),
        .DATA_W     (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe_wr   (pipe_wr),
        .pipe_rd   (pipe_rd),
        .pipe_data (pipe_data),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_rd     (lu_rd),
        .lu_data   (lu_data),
        .issue_vld (issue_vld),
        .issue_rd  (issue_rd),
        .RFWr      (RFWr),
        .WrDtAdr   (WrDtAdr),
        .WrDt      (WrDt),
        .busy      (busy),
        .wb_stall  (wb_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        pw;
        logic [4:0]  prd;
        logic [31:0] pdat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        iv;
        logic [4:0]  ird;
        logic        e_wr;
        logic [4:0]  e_adr;
        logic [31:0] e_dat;
        logic [31:0] e_busy;
        logic        e_rdy;
        logic        e_stall;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the FIFO is a plain queue, starvation a count of consecutive losses.
    ent_t        m_q[$];
    bit          m_rfwr;
    logic [4:0]  m_adr;
    logic [31:0] m_dat;
    bit   [31:0] m_busy;
    bit          m_stall;
    bit          m_stall_was;
    bit          m_lu_acc;
    int          m_losses;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rfwr      = 1'b0;
        m_adr       = '0;
        m_dat       = '0;
        m_busy      = '0;
        m_stall     = 1'b0;
        m_stall_was = 1'b0;
        m_lu_acc    = 1'b0;
        m_losses    = 0;
    endtask

    task automatic model_step();
        bit   rdy;
        bit   do_pop;
        bit   do_pipe;
        bit   nxt_stall;
        ent_t h;
        rdy     = (m_q.size() < DEPTH);
        do_pop  = 1'b0;
        do_pipe = 1'b0;
        if (m_stall) do_pop = (m_q.size() != 0);
        else if (pipe_wr && pipe_rd != 5'd0) do_pipe = 1'b1;
        else if (m_q.size() != 0) do_pop = 1'b1;
        nxt_stall = !m_stall && (m_losses >= STARVE_MAX);
        if (m_q.size() == 0 || do_pop) m_losses = 0;
        else if (do_pipe) m_losses++;
        m_stall_was = m_stall;
        m_stall     = nxt_stall;
        if (do_pipe) begin
            m_rfwr = 1'b1;
            m_adr  = pipe_rd;
            m_dat  = pipe_data;
        end else if (do_pop) begin
            h = m_q.pop_front();
            m_rfwr = 1'b1;
            m_adr  = h.rd;
            m_dat  = h.data;
            m_busy[h.rd] = 1'b0;
        end else begin
            m_rfwr = 1'b0;
        end
        if (issue_vld && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        m_lu_acc = lu_valid && rdy;
        if (m_lu_acc && lu_rd != 5'd0) m_q.push_back('{rd: lu_rd, data: lu_data});
    endtask

    task automatic check_all();
        chk("RFWr", 64'(RFWr), 64'(m_rfwr));
        chk("WrDtAdr", 64'(WrDtAdr), 64'(m_adr));
        chk("WrDt", 64'(WrDt), 64'(m_dat));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("wb_stall", 64'(wb_stall), 64'(m_stall));
        chk("lu_ready", 64'(lu_ready), 64'(m_q.size() < DEPTH));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[11];
        int   stall_k;
        int   head_k;
        int   nxt;
        int   n_wr3;

        rst = 1'b1;
        pipe_wr = 1'b0; pipe_rd = '0; pipe_data = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
        issue_vld = 1'b0; issue_rd = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #3 rst = 1'b0;

        // Directed table from reset: single pipe write, busy tracking, no-op rd=0,
        // FIFO fill with back-pressure, in-order drain, same-cycle set/clear.
        vecs[0]  = '{1'b1, 5'd5,  32'hAAAA5555, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,
                     1'b1, 5'd5,  32'hAAAA5555, 32'h0,   1'b1, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 5'd7,
                     1'b0, 5'd5,  32'hAAAA5555, 32'h80,  1'b1, 1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h12,   1'b0, 5'd0,
                     1'b0, 5'd5,  32'hAAAA5555, 32'h80,  1'b1, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0,
                     1'b1, 5'd7,  32'h12,       32'h0,   1'b1, 1'b0};
        vecs[4]  = '{1'b1, 5'd0,  32'hDEAD,     1'b1, 5'd0,  32'hBEEF, 1'b0, 5'd0,
                     1'b0, 5'd7,  32'h12,       32'h0,   1'b1, 1'b0};
        vecs[5]  = '{1'b1, 5'd6,  32'h66,       1'b1, 5'd10, 32'h100,  1'b1, 5'd10,
                     1'b1, 5'd6,  32'h66,       32'h400, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 5'd6,  32'h67,       1'b1, 5'd11, 32'h101,  1'b0, 5'd0,
                     1'b1, 5'd6,  32'h67,       32'h400, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h102,  1'b1, 5'd10,
                     1'b1, 5'd10, 32'h100,      32'h400, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h102,  1'b0, 5'd0,
                     1'b1, 5'd11, 32'h101,      32'h400, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 5'd0,
                     1'b1, 5'd12, 32'h102,      32'h400, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0,
                     1'b0, 5'd12, 32'h102,      32'h400, 1'b1, 1'b0};

        for (int i = 0; i < 11; i++) begin
            pipe_wr = vecs[i].pw; pipe_rd = vecs[i].prd; pipe_data = vecs[i].pdat;
            lu_valid = vecs[i].lv; lu_rd = vecs[i].lrd; lu_data = vecs[i].ldat;
            issue_vld = vecs[i].iv; issue_rd = vecs[i].ird;
            cycle();
            chk($sformatf("vec%0d_RFWr", i), 64'(RFWr), 64'(vecs[i].e_wr));
            chk($sformatf("vec%0d_WrDtAdr", i), 64'(WrDtAdr), 64'(vecs[i].e_adr));
            chk($sformatf("vec%0d_WrDt", i), 64'(WrDt), 64'(vecs[i].e_dat));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
            chk($sformatf("vec%0d_lu_ready", i), 64'(lu_ready), 64'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_wb_stall", i), 64'(wb_stall), 64'(vecs[i].e_stall));
        end

        // Starvation: one queued entry against a continuous pipe stream to rd=3.
        issue_vld = 1'b0;
        pipe_wr = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h300;
        lu_valid = 1'b1; lu_rd = 5'd20; lu_data = 32'h200;
        stall_k = -1; head_k = -1; nxt = 1; n_wr3 = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (k == 0) lu_valid = 1'b0;
            if (RFWr === 1'b1 && WrDtAdr == 5'd3) begin
                chk("starve_pipe_order", 64'(WrDt), 64'(32'h300 + 32'(n_wr3)));
                n_wr3++;
            end
            if (wb_stall === 1'b1 && stall_k < 0) stall_k = k;
            if (RFWr === 1'b1 && WrDtAdr == 5'd20) begin
                head_k = k;
                chk("starve_head_data", 64'(WrDt), 64'(32'h200));
            end
            if (k >= 8) pipe_wr = 1'b0;
            else if (!m_stall_was) begin
                pipe_data = 32'h300 + 32'(nxt);
                nxt++;
            end
        end
        chk("starve_stall_cycle", 64'(stall_k), 64'(STARVE_MAX + 1));
        chk("starve_head_cycle", 64'(head_k), 64'(STARVE_MAX + 2));
        chk("starve_pipe_count", 64'(n_wr3), 64'(nxt));

        // Reset with two queued entries and busy[9] set.
        pipe_wr = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h900;
        issue_vld = 1'b1; issue_rd = 5'd9;
        cycle();
        issue_vld = 1'b0; lu_rd = 5'd13; lu_data = 32'hD00;
        cycle();
        chk("prereset_busy9", 64'(busy[9]), 64'(1));
        chk("prereset_full", 64'(lu_ready), 64'(0));
        pipe_wr = 1'b0; lu_valid = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("postreset_no_write", 64'(RFWr), 64'(0));
        end

        // Randomized traffic with bursts of heavy pipe load to provoke starvation stalls.
        for (int c = 0; c < 3000; c++) begin
            int pct;
            pct = (((c / 64) % 2) == 1) ? 90 : 35;
            if (!m_stall_was) begin
                pipe_wr   = ($urandom_range(0, 99) < pct);
                pipe_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                pipe_data = $urandom;
            end
            if (!(lu_valid && !m_lu_acc)) begin
                lu_valid = ($urandom_range(0, 99) < 30);
                lu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                lu_data  = $urandom;
            end
            issue_vld = ($urandom_range(0, 99) < 20);
            issue_rd  = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
